// File: rtl/filter_sched_pkg.sv
// Shared types and defaults for the filter scheduler: FSM encoding, counter
// widths, parameter defaults and the two-source round-robin pick rule.
package filter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BURST = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int FRAME_PIX_DEF = 25;
  localparam int NUM_RES_DEF   = 9;
  localparam int WD_LIMIT_DEF  = 64;

  localparam int PIX_IDX_W = 5;
  localparam int RES_CNT_W = 4;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 16;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // On a tie the source that did not win last time gets the grant.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_gnt);
    logic g;
    if (req0 && req1) begin
      g = ~last_gnt;
    end else if (req1) begin
      g = SRC1;
    end else begin
      g = SRC0;
    end
    return g;
  endfunction

endpackage

// File: rtl/filter_rr_arb.sv
// Two-source round-robin arbiter; remembers the last granted source so a
// tie alternates between sources. Reset leaves source 1 as last winner.
module filter_rr_arb
  import filter_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt
);

  logic last_r;
  logic gnt_s;

  // Grant decision for the current request pair.
  always_comb begin
    gnt_s = rr_pick(req0, req1, last_r);
  end

  assign gnt = gnt_s;

  // Last-winner history, updated only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= SRC1;
    end else if (take) begin
      last_r <= gnt_s;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/filter_sched.sv
// Frame scheduler for a 5x5 filter engine: buffers one frame from the granted
// source, bursts it to the engine, then collects results under a watchdog.
module filter_sched
  import filter_sched_pkg::*;
#(
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int NUM_RES   = NUM_RES_DEF,
  parameter int WD_LIMIT  = WD_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] s0_din,
  input  logic [PIX_W-1:0] s1_din,
  input  logic             s0_valid,
  input  logic             s1_valid,
  output logic             s0_ready,
  output logic             s1_ready,
  output logic [PIX_W-1:0] eng_din,
  output logic             eng_valid,
  input  logic             eng_fill_now,
  input  logic [RES_W-1:0] eng_dout,
  input  logic             eng_res_valid,
  output logic [RES_W-1:0] res_data,
  output logic             res_src,
  output logic             res_valid,
  output logic             frame_done,
  output logic             wd_err
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  state_t state_r, state_n_s;

  logic                 grant_r, grant_n_s, arb_gnt_s, arb_take_s;
  logic [PIX_IDX_W-1:0] wr_idx_r, rd_idx_r;
  logic                 burst_on_r;
  logic [RES_CNT_W-1:0] res_cnt_r;
  logic [WD_W-1:0]      wd_cnt_r;
  logic [PIX_W-1:0]     pix_mem_r [FRAME_PIX];

  logic             src_valid_s, src_ready_s;
  logic [PIX_W-1:0] src_din_s;
  logic             wr_fire_s, last_wr_s, beat_s, burst_done_s;
  logic             res_take_s, last_res_s, wd_hit_s;

  logic             s0_ready_r, s1_ready_r, eng_valid_r, res_src_r;
  logic             res_valid_r, frame_done_r, wd_err_r;
  logic [PIX_W-1:0] eng_din_r;
  logic [RES_W-1:0] res_data_r;

  logic             s0_ready_n_s, s1_ready_n_s, eng_valid_n_s, res_src_n_s;
  logic             res_valid_n_s, frame_done_n_s, wd_err_n_s;
  logic [PIX_W-1:0] eng_din_n_s;
  logic [RES_W-1:0] res_data_n_s;

  filter_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (s0_valid),
    .req1 (s1_valid),
    .take (arb_take_s),
    .gnt  (arb_gnt_s)
  );

  // Event decode shared by the FSM, counters and output logic.
  always_comb begin
    arb_take_s   = (state_r == ST_IDLE) && (s0_valid || s1_valid);
    grant_n_s    = arb_take_s ? arb_gnt_s : grant_r;
    src_valid_s  = grant_r ? s1_valid : s0_valid;
    src_din_s    = grant_r ? s1_din : s0_din;
    src_ready_s  = grant_r ? s1_ready_r : s0_ready_r;
    wr_fire_s    = (state_r == ST_LOAD) && src_ready_s && src_valid_s;
    last_wr_s    = wr_fire_s && (wr_idx_r == PIX_IDX_W'(FRAME_PIX - 1));
    // Once the burst has started it runs to completion regardless of fill_now.
    beat_s       = (state_r == ST_BURST) && (rd_idx_r != PIX_IDX_W'(FRAME_PIX)) &&
                   (burst_on_r || eng_fill_now);
    burst_done_s = (state_r == ST_BURST) && (rd_idx_r == PIX_IDX_W'(FRAME_PIX));
    res_take_s   = (state_r == ST_WAIT) && eng_res_valid;
    last_res_s   = res_take_s && (res_cnt_r == RES_CNT_W'(NUM_RES - 1));
    wd_hit_s     = (state_r == ST_WAIT) && !eng_res_valid &&
                   (wd_cnt_r == WD_W'(WD_LIMIT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (s0_valid || s1_valid) state_n_s = ST_LOAD;
        else                      state_n_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (last_wr_s) state_n_s = ST_BURST;
        else           state_n_s = ST_LOAD;
      end
      ST_BURST: begin
        if (burst_done_s) state_n_s = ST_WAIT;
        else              state_n_s = ST_BURST;
      end
      ST_WAIT: begin
        if (last_res_s)    state_n_s = ST_IDLE;
        else if (wd_hit_s) state_n_s = ST_IDLE;
        else               state_n_s = ST_WAIT;
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    s0_ready_n_s   = (state_n_s == ST_LOAD) && (grant_n_s == SRC0);
    s1_ready_n_s   = (state_n_s == ST_LOAD) && (grant_n_s == SRC1);
    eng_valid_n_s  = beat_s;
    if (beat_s) begin
      eng_din_n_s = pix_mem_r[rd_idx_r];
    end else begin
      eng_din_n_s = {PIX_W{1'b0}};
    end
    res_valid_n_s  = res_take_s;
    if (res_take_s) begin
      res_data_n_s = eng_dout;
      res_src_n_s  = grant_r;
    end else begin
      res_data_n_s = res_data_r;
      res_src_n_s  = res_src_r;
    end
    frame_done_n_s = last_res_s;
    wd_err_n_s     = wd_err_r || wd_hit_s;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_ready_r   <= 1'b0;
      s1_ready_r   <= 1'b0;
      eng_valid_r  <= 1'b0;
      eng_din_r    <= {PIX_W{1'b0}};
      res_valid_r  <= 1'b0;
      res_data_r   <= {RES_W{1'b0}};
      res_src_r    <= 1'b0;
      frame_done_r <= 1'b0;
      wd_err_r     <= 1'b0;
    end else begin
      s0_ready_r   <= s0_ready_n_s;
      s1_ready_r   <= s1_ready_n_s;
      eng_valid_r  <= eng_valid_n_s;
      eng_din_r    <= eng_din_n_s;
      res_valid_r  <= res_valid_n_s;
      res_data_r   <= res_data_n_s;
      res_src_r    <= res_src_n_s;
      frame_done_r <= frame_done_n_s;
      wd_err_r     <= wd_err_n_s;
    end
  end

  // Grant, fill/read indices, result count and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_r    <= 1'b0;
      wr_idx_r   <= {PIX_IDX_W{1'b0}};
      rd_idx_r   <= {PIX_IDX_W{1'b0}};
      burst_on_r <= 1'b0;
      res_cnt_r  <= {RES_CNT_W{1'b0}};
      wd_cnt_r   <= {WD_W{1'b0}};
    end else begin
      grant_r <= grant_n_s;
      if (arb_take_s) begin
        wr_idx_r  <= {PIX_IDX_W{1'b0}};
        res_cnt_r <= {RES_CNT_W{1'b0}};
      end else begin
        if (wr_fire_s) wr_idx_r <= wr_idx_r + PIX_IDX_W'(1);
        else           wr_idx_r <= wr_idx_r;
        if (res_take_s) res_cnt_r <= res_cnt_r + RES_CNT_W'(1);
        else            res_cnt_r <= res_cnt_r;
      end
      if (last_wr_s) begin
        rd_idx_r   <= {PIX_IDX_W{1'b0}};
        burst_on_r <= 1'b0;
      end else if (beat_s) begin
        rd_idx_r   <= rd_idx_r + PIX_IDX_W'(1);
        burst_on_r <= 1'b1;
      end else begin
        rd_idx_r   <= rd_idx_r;
        burst_on_r <= burst_on_r;
      end
      // Zero outside WAIT, so it is already clear on entry; restarts on each result.
      if ((state_r == ST_WAIT) && !eng_res_valid) wd_cnt_r <= wd_cnt_r + WD_W'(1);
      else                                        wd_cnt_r <= {WD_W{1'b0}};
    end
  end

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      pix_mem_r[wr_idx_r] <= src_din_s;
    end else begin
      pix_mem_r[wr_idx_r] <= pix_mem_r[wr_idx_r];
    end
  end

  assign s0_ready   = s0_ready_r;
  assign s1_ready   = s1_ready_r;
  assign eng_valid  = eng_valid_r;
  assign eng_din    = eng_din_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_src    = res_src_r;
  assign frame_done = frame_done_r;
  assign wd_err     = wd_err_r;

endmodule

// File: tb/tb_filter_sched.sv
// Directed testbench for filter_sched with hand-computed frame contents,
// result sequences, arbitration order and watchdog timing.
module tb_filter_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s0_din = 8'd0, s1_din = 8'd0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [7:0]  eng_din;
  logic        eng_valid;
  logic        eng_fill_now = 1'b1;
  logic [15:0] eng_dout = 16'd0;
  logic        eng_res_valid = 1'b0;
  logic [15:0] res_data;
  logic        res_src, res_valid, frame_done, wd_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int orphan_fd = 0;

  logic [7:0]  eng_q[$];
  int          eng_cyc_q[$];
  logic [15:0] rd_q[$];
  logic        rs_q[$];
  logic        fd_q[$];
  int          res_cyc_q[$];
  int          pulse_cyc_q[$];

  filter_sched dut (
    .clk(clk), .rst(rst),
    .s0_din(s0_din), .s1_din(s1_din), .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .eng_din(eng_din), .eng_valid(eng_valid), .eng_fill_now(eng_fill_now),
    .eng_dout(eng_dout), .eng_res_valid(eng_res_valid),
    .res_data(res_data), .res_src(res_src), .res_valid(res_valid),
    .frame_done(frame_done), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_valid === 1'b1) begin
      eng_q.push_back(eng_din);
      eng_cyc_q.push_back(cyc);
    end
    if (res_valid === 1'b1) begin
      rd_q.push_back(res_data);
      rs_q.push_back(res_src);
      fd_q.push_back(frame_done);
      res_cyc_q.push_back(cyc);
    end else if (frame_done === 1'b1) begin
      orphan_fd++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    eng_q.delete(); eng_cyc_q.delete(); rd_q.delete(); rs_q.delete();
    fd_q.delete(); res_cyc_q.delete(); pulse_cyc_q.delete();
    orphan_fd = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
  endtask

  // Streams pixels base+1..base+npix from one source, optionally with a
  // valid gap every 3rd cycle and with the other source requesting too.
  task automatic send_frame(input bit src, input bit gaps, input bit other_busy,
                            input int base, input int npix, output bit to, output int other_hi);
    int p = 1;
    int c = 0;
    int guard = 0;
    bit v, acc;
    to = 1'b0;
    other_hi = 0;
    while (p <= npix && !to) begin
      c++;
      v = !(gaps && (c % 3 == 0));
      if (src == 1'b0) begin
        s0_valid = v; s0_din = 8'(base + p); s1_valid = other_busy; s1_din = 8'hEE;
      end else begin
        s1_valid = v; s1_din = 8'(base + p); s0_valid = other_busy; s0_din = 8'hEE;
      end
      @(negedge clk);
      acc = v && (src ? s1_ready : s0_ready);
      if (src ? s0_ready : s1_ready) other_hi++;
      @(posedge clk); #1;
      if (acc) p++;
      guard++;
      if (guard > 400) to = 1'b1;
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic wait_burst(output bit to);
    int g = 0;
    to = 1'b0;
    while (eng_q.size() < 25 && !to) begin
      @(posedge clk); #1;
      g++;
      if (g > 300) to = 1'b1;
    end
    tick(4);
  endtask

  task automatic send_results(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      eng_res_valid = 1'b1;
      eng_dout = base + 16'(i);
      pulse_cyc_q.push_back(cyc);
      @(posedge clk); #1;
      eng_res_valid = 1'b0;
      eng_dout = 16'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    vec_cnt++;
    if ({s0_ready, s1_ready, eng_valid, eng_din, res_data, res_src, res_valid, frame_done, wd_err} !== 31'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %0h required 0", {s0_ready, s1_ready, eng_valid, eng_din, res_data, res_src, res_valid, frame_done, wd_err});
    end
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    vec_cnt++;
    if ({s0_ready, s1_ready, eng_valid, res_valid, frame_done, wd_err} !== 6'd0) begin
      err_cnt++;
      $display("FAIL idle_outputs: got %0h required 0", {s0_ready, s1_ready, eng_valid, res_valid, frame_done, wd_err});
    end
  endtask

  task automatic test_ignore_res();
    clear_logs();
    eng_res_valid = 1'b1; eng_dout = 16'hDEAD;
    tick(1);
    eng_res_valid = 1'b0; eng_dout = 16'd0;
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 0 || orphan_fd != 0) begin
      err_cnt++;
      $display("FAIL ignore_res_idle: got %0d results required 0", rd_q.size());
    end
  endtask

  task automatic test_single();
    bit to; int oh; int span;
    clear_logs();
    send_frame(1'b0, 1'b0, 1'b0, 0, 25, to, oh);
    vec_cnt++;
    if (to !== 1'b0) begin err_cnt++; $display("FAIL single_load_timeout: got %0d required 0", to); end
    wait_burst(to);
    vec_cnt++;
    if (to !== 1'b0 || eng_q.size() != 25) begin
      err_cnt++; $display("FAIL single_beats: got %0d beats required 25", eng_q.size());
    end
    for (int i = 0; i < eng_q.size() && i < 25; i++) begin
      vec_cnt++;
      if (eng_q[i] !== 8'(i + 1)) begin
        err_cnt++; $display("FAIL single_pix[%0d]: got %0d required %0d", i, eng_q[i], i + 1);
      end
    end
    span = (eng_cyc_q.size() >= 25) ? eng_cyc_q[24] - eng_cyc_q[0] : -1;
    vec_cnt++;
    if (span != 24) begin err_cnt++; $display("FAIL single_contig: got span %0d required 24", span); end
    send_results(9, 16'h1000);
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 9 || orphan_fd != 0) begin
      err_cnt++; $display("FAIL single_res_count: got %0d required 9", rd_q.size());
    end
    for (int i = 0; i < rd_q.size() && i < 9; i++) begin
      vec_cnt++;
      if ({rs_q[i], rd_q[i], fd_q[i]} !== {1'b0, 16'h1000 + 16'(i), (i == 8)}) begin
        err_cnt++;
        $display("FAIL single_res[%0d]: got src=%0d data=%0h done=%0d required src=0 data=%0h done=%0d",
                 i, rs_q[i], rd_q[i], fd_q[i], 16'h1000 + 16'(i), (i == 8));
      end
      vec_cnt++;
      if (res_cyc_q[i] != pulse_cyc_q[i] + 1) begin
        err_cnt++; $display("FAIL single_latency[%0d]: got %0d required 1", i, res_cyc_q[i] - pulse_cyc_q[i]);
      end
    end
    vec_cnt++;
    if (wd_err !== 1'b0) begin err_cnt++; $display("FAIL single_wd: got %0d required 0", wd_err); end
  endtask

  task automatic test_arb();
    bit to; int oh;
    pulse_reset();
    for (int f = 0; f < 2; f++) begin
      clear_logs();
      send_frame(f[0], 1'b0, 1'b1, 64 * f, 25, to, oh);
      vec_cnt++;
      if (to !== 1'b0 || oh != 0) begin
        err_cnt++; $display("FAIL arb_grant_f%0d: got timeout=%0d other_ready=%0d required 0 0", f, to, oh);
      end
      wait_burst(to);
      vec_cnt++;
      if (eng_q.size() != 25) begin err_cnt++; $display("FAIL arb_beats_f%0d: got %0d required 25", f, eng_q.size()); end
      for (int i = 0; i < eng_q.size() && i < 25; i++) begin
        vec_cnt++;
        if (eng_q[i] !== 8'(64 * f + i + 1)) begin
          err_cnt++; $display("FAIL arb_pix_f%0d[%0d]: got %0h required %0h", f, i, eng_q[i], 64 * f + i + 1);
        end
      end
      send_results(9, 16'h2000);
      tick(3);
      vec_cnt++;
      if (rd_q.size() != 9) begin err_cnt++; $display("FAIL arb_res_count_f%0d: got %0d required 9", f, rd_q.size()); end
      for (int i = 0; i < rd_q.size() && i < 9; i++) begin
        vec_cnt++;
        if ({rs_q[i], fd_q[i]} !== {f[0], (i == 8)}) begin
          err_cnt++; $display("FAIL arb_res_src_f%0d[%0d]: got src=%0d done=%0d required src=%0d done=%0d",
                              f, i, rs_q[i], fd_q[i], f[0], (i == 8));
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit to; int oh; int span;
    clear_logs();
    send_frame(1'b0, 1'b1, 1'b0, 0, 25, to, oh);
    vec_cnt++;
    if (to !== 1'b0) begin err_cnt++; $display("FAIL gaps_load_timeout: got %0d required 0", to); end
    wait_burst(to);
    vec_cnt++;
    if (eng_q.size() != 25) begin err_cnt++; $display("FAIL gaps_beats: got %0d required 25", eng_q.size()); end
    for (int i = 0; i < eng_q.size() && i < 25; i++) begin
      vec_cnt++;
      if (eng_q[i] !== 8'(i + 1)) begin
        err_cnt++; $display("FAIL gaps_pix[%0d]: got %0d required %0d", i, eng_q[i], i + 1);
      end
    end
    span = (eng_cyc_q.size() >= 25) ? eng_cyc_q[24] - eng_cyc_q[0] : -1;
    vec_cnt++;
    if (span != 24) begin err_cnt++; $display("FAIL gaps_contig: got span %0d required 24", span); end
    send_results(9, 16'h3000);
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 9) begin err_cnt++; $display("FAIL gaps_res_count: got %0d required 9", rd_q.size()); end
  endtask

  task automatic test_fill_stall();
    bit to; int oh; int span;
    clear_logs();
    eng_fill_now = 1'b0;
    send_frame(1'b0, 1'b0, 1'b0, 128, 25, to, oh);
    tick(10);
    vec_cnt++;
    if (to !== 1'b0 || eng_q.size() != 0) begin
      err_cnt++; $display("FAIL stall_hold: got %0d beats while fill_now low required 0", eng_q.size());
    end
    eng_fill_now = 1'b1;
    wait_burst(to);
    vec_cnt++;
    if (eng_q.size() != 25) begin err_cnt++; $display("FAIL stall_beats: got %0d required 25", eng_q.size()); end
    for (int i = 0; i < eng_q.size() && i < 25; i++) begin
      vec_cnt++;
      if (eng_q[i] !== 8'(128 + i + 1)) begin
        err_cnt++; $display("FAIL stall_pix[%0d]: got %0h required %0h", i, eng_q[i], 128 + i + 1);
      end
    end
    span = (eng_cyc_q.size() >= 25) ? eng_cyc_q[24] - eng_cyc_q[0] : -1;
    vec_cnt++;
    if (span != 24) begin err_cnt++; $display("FAIL stall_contig: got span %0d required 24", span); end
    send_results(9, 16'h4000);
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 9) begin err_cnt++; $display("FAIL stall_res_count: got %0d required 9", rd_q.size()); end
  endtask

  task automatic test_watchdog();
    bit to; int oh; int nfd;
    clear_logs();
    send_frame(1'b0, 1'b0, 1'b0, 0, 25, to, oh);
    wait_burst(to);
    send_results(5, 16'h5000);
    tick(63);
    @(negedge clk);
    vec_cnt++;
    if (wd_err !== 1'b0) begin err_cnt++; $display("FAIL wd_early: got %0d at 64th idle cycle required 0", wd_err); end
    tick(1);
    @(negedge clk);
    vec_cnt++;
    if (wd_err !== 1'b1) begin err_cnt++; $display("FAIL wd_fire: got %0d after 64 idle cycles required 1", wd_err); end
    nfd = orphan_fd;
    foreach (fd_q[i]) if (fd_q[i]) nfd++;
    vec_cnt++;
    if (rd_q.size() != 5 || nfd != 0) begin
      err_cnt++; $display("FAIL wd_partial: got results=%0d done=%0d required 5 0", rd_q.size(), nfd);
    end
    clear_logs();
    send_frame(1'b0, 1'b0, 1'b0, 32, 25, to, oh);
    vec_cnt++;
    if (to !== 1'b0) begin err_cnt++; $display("FAIL wd_next_load: got timeout %0d required 0", to); end
    wait_burst(to);
    vec_cnt++;
    if (eng_q.size() != 25 || eng_q[0] !== 8'd33 || eng_q[24] !== 8'd57) begin
      err_cnt++; $display("FAIL wd_next_burst: got %0d beats required 25 of 33..57", eng_q.size());
    end
    send_results(9, 16'h6000);
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 9 || fd_q[8] !== 1'b1 || rd_q[8] !== 16'h6008) begin
      err_cnt++; $display("FAIL wd_next_res: got %0d results required 9 ending 6008 with done", rd_q.size());
    end
    vec_cnt++;
    if (wd_err !== 1'b1) begin err_cnt++; $display("FAIL wd_sticky: got %0d required 1", wd_err); end
  endtask

  task automatic test_reset_mid();
    bit to; int oh;
    clear_logs();
    send_frame(1'b0, 1'b0, 1'b0, 0, 12, to, oh);
    vec_cnt++;
    if (to !== 1'b0 || s0_ready !== 1'b1) begin
      err_cnt++; $display("FAIL mid_load_ready: got %0d required 1", s0_ready);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({s0_ready, s1_ready, eng_valid, eng_din, res_data, res_src, res_valid, frame_done, wd_err} !== 31'd0) begin
      err_cnt++;
      $display("FAIL mid_reset_outputs: got %0h required 0", {s0_ready, s1_ready, eng_valid, eng_din, res_data, res_src, res_valid, frame_done, wd_err});
    end
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    clear_logs();
    send_frame(1'b0, 1'b0, 1'b0, 100, 25, to, oh);
    vec_cnt++;
    if (to !== 1'b0) begin err_cnt++; $display("FAIL mid_new_load: got timeout %0d required 0", to); end
    wait_burst(to);
    vec_cnt++;
    if (eng_q.size() != 25) begin err_cnt++; $display("FAIL mid_new_beats: got %0d required 25", eng_q.size()); end
    for (int i = 0; i < eng_q.size() && i < 25; i++) begin
      vec_cnt++;
      if (eng_q[i] !== 8'(100 + i + 1)) begin
        err_cnt++; $display("FAIL mid_new_pix[%0d]: got %0d required %0d", i, eng_q[i], 100 + i + 1);
      end
    end
    send_results(9, 16'h7000);
    tick(3);
    vec_cnt++;
    if (rd_q.size() != 9 || wd_err !== 1'b0) begin
      err_cnt++; $display("FAIL mid_new_res: got results=%0d wd=%0d required 9 0", rd_q.size(), wd_err);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_res();
    test_single();
    test_arb();
    test_gaps();
    test_fill_stall();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/filter_sched.md
FILTER_SCHED -- requirements
Module: filter_sched

Interface
Parameters (name, default, meaning):
REQ-001 FRAME_PIX, 25, pixels per frame delivered to the 5x5 filter engine.
REQ-002 NUM_RES, 9, results the engine produces per frame.
REQ-003 WD_LIMIT, 64, result-wait watchdog limit in cycles.

Ports (name direction width meaning):
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 s0_din / s1_din  input  8  pixel from source 0 / source 1.
REQ-007 s0_valid / s1_valid  input  1  source pixel valid.
REQ-008 s0_ready / s1_ready  output  1  scheduler accepts pixel this cycle.
REQ-009 eng_din  output  8  pixel to filter engine.
REQ-010 eng_valid  output  1  engine data_valid strobe.
REQ-011 eng_fill_now  input  1  engine idle/accepting flag (high = storage free).
REQ-012 eng_dout  input  16  engine result.
REQ-013 eng_res_valid  input  1  engine result strobe, one per convolution.
REQ-014 res_data  output  16  registered result.
REQ-015 res_src  output  1  source id of res_data.
REQ-016 res_valid  output  1  one-cycle result strobe.
REQ-017 frame_done  output  1  one-cycle pulse after NUM_RES-th result of a frame.
REQ-018 wd_err  output  1  sticky watchdog error; cleared only by reset.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, BURST, WAIT; reset state IDLE.
REQ-020 IDLE: if either sN_valid high, grant SHALL be chosen and FSM moves to LOAD next cycle; if both high, grant SHALL go to the source not granted last (source 0 first after reset).
REQ-021 LOAD: sN_ready SHALL be high only for the granted source; each cycle with sN_valid&&sN_ready writes the pixel into a FRAME_PIX x 8 buffer at index wr_idx, wr_idx+1.
REQ-022 Source valid gaps in LOAD SHALL stall the buffer fill without loss or reorder; the ungranted source SHALL see ready low throughout.
REQ-023 After pixel FRAME_PIX-1 is written, FSM SHALL go to BURST; grant is not changed until the next IDLE.
REQ-024 BURST SHALL start only when eng_fill_now is high, then drive eng_valid high for exactly FRAME_PIX consecutive cycles with buffer[0..FRAME_PIX-1] in order, no gaps; then move to WAIT.
REQ-025 eng_valid SHALL be low in all states except BURST.
REQ-026 WAIT: each eng_res_valid SHALL register eng_dout into res_data, grant into res_src, assert res_valid next cycle (latency 1).
REQ-027 On the NUM_RES-th result, frame_done SHALL pulse in the same cycle as that res_valid and FSM SHALL return to IDLE.
REQ-028 eng_res_valid outside WAIT SHALL be ignored (no res_valid).
REQ-029 Watchdog: counter cleared on entering WAIT and on each result; reaching WD_LIMIT in WAIT SHALL set wd_err, drop the frame and return to IDLE.
REQ-030 Result counter SHALL be 4 bits, pixel index 5 bits; both cleared on entering LOAD.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, all counters 0, last-grant to source 1 (so source 0 wins first tie), all outputs 0.
REQ-032 Reset mid-LOAD/BURST/WAIT SHALL discard the partial frame; buffer contents need not be cleared.

Structure
REQ-033 State encodings, FRAME_PIX, NUM_RES and WD_LIMIT defaults SHALL live in a shared package/include file.
REQ-034 The two-source round-robin grant SHALL be one sub-module, filter_rr_arb.

Verification
REQ-035 Single source 0 streams pixels 1..25 back-to-back -> eng_din 1..25 on 25 consecutive eng_valid cycles; 9 engine results -> 9 res_valid with res_src=0, frame_done on the 9th.
REQ-036 Both sources valid in IDLE after reset -> source 0 granted; next frame with both valid -> source 1 granted.
REQ-037 Source 0 drops valid every 3rd cycle during LOAD -> eng_din still 1..25 contiguous, no gaps on eng_valid.
REQ-038 eng_fill_now held low 10 cycles after LOAD completes -> eng_valid stays low until fill_now rises, then 25-cycle burst.
REQ-039 Only 5 results returned -> wd_err=1 after 64 idle WAIT cycles, FSM IDLE, next frame accepted.
REQ-040 rst pulsed low at pixel 12 of LOAD -> all outputs 0 immediately; new frame after release starts at buffer index 0.
